// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// FSM state encoding, slice width and the saturation bound helper.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Most-positive (neg=0) or most-negative (neg=1) value of a width-bit
    // two's-complement number, zero-extended to 64 bits. Valid for width 1..64.
    function automatic logic [63:0] sat_value(input int unsigned width, input logic neg);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        return neg ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/adder_4_slice.sv
// Combinational 4-bit adder slice. Also exports the carry into bit 3 so the
// controller can derive signed overflow on the most significant nibble.
module adder_4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] lo;
    logic [1:0] hi;

    // Split at bit 3 so the internal carry is directly observable.
    always_comb begin
        lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        hi   = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, lo[3]};
        s    = {hi[0], lo[2:0]};
        c3   = lo[3];
        cout = hi[1];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built around one shared 4-bit slice,
// processing one nibble per clock LSB first, with a start/done handshake.
// WIDTH must be a multiple of 4, between 4 and 64.
// Optional build macro SERIAL_ADD_SAT_EN: saturate sum on signed overflow.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NumNib = WIDTH / NIBBLE_W;
    localparam int unsigned KW     = (NumNib > 1) ? $clog2(NumNib) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic                slice_c3;
    logic                last_nib;

    // Operands shift right each RUN cycle, so the active nibble is always [3:0].
    adder_4_slice u_slice (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    assign last_nib = (k_q == KW'(NumNib - 1));

    // Next-state logic: operand capture, nibble sequencing and result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    k_d     = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[k_q*NIBBLE_W +: NIBBLE_W] = slice_s;
                carry_d = slice_cout;
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                k_d     = k_q + KW'(1);
                if (last_nib) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_c3 ^ slice_cout;
                    k_d     = '0;
                    state_d = StDone;
`ifdef SERIAL_ADD_SAT_EN
                    // a_q[3] now holds the original sign bit of A.
                    if (slice_c3 ^ slice_cout) begin
                        sum_d = WIDTH'(sat_value(WIDTH, a_q[NIBBLE_W-1]));
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode the registered state, so done is a clean pulse.
    always_comb begin
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
        sum      = sum_q;
        cout     = cout_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference: signed integer arithmetic for result/overflow, unsigned
    // 17-bit arithmetic for the carry out.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, output logic [W-1:0] es,
                                  output logic ec, output logic eo);
        int r;
        logic [W:0] u;
        r  = ms ? (int'($signed(ma)) - int'($signed(mb)))
                : (int'($signed(ma)) + int'($signed(mb)));
        eo = (r > 32767) || (r < -32768);
        u  = ms ? ({1'b0, ma} + {1'b0, ~mb} + 17'd1) : ({1'b0, ma} + {1'b0, mb});
        ec = u[W];
        es = u[W-1:0];
`ifdef SERIAL_ADD_SAT_EN
        if (eo) es = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    // Launch one operation from a negedge; return the cycle done appeared in
    // (start edge = edge 0, sampled at negedges) or -1 on timeout, plus the
    // per-cycle busy history (bit c = busy in cycle c).
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                         output int lat, output logic [31:0] busy_hist);
        lat = -1;
        busy_hist = '0;
        a = ia; b = ib; sub = is; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            busy_hist[c] = busy;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, overflow} !== 20'd0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, overflow);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'h1234, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [W-1:0] vb [4] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0001};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] es;
        logic ec, eo;
        int lat;
        logic [31:0] bh;
        for (int i = 0; i < 4; i++) begin
            model(va[i], vb[i], vs[i], es, ec, eo);
            do_op(va[i], vb[i], vs[i], lat, bh);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL dir%0d latency: got %0d want 5", i, lat);
            end
            checks++;
            if ({sum, cout, overflow} !== {es, ec, eo}) begin
                errors++;
                $display("FAIL dir%0d result: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                         i, sum, cout, overflow, es, ec, eo);
            end
            if (i == 0) begin
                checks++;
                if (bh[5:1] !== 5'b01111) begin
                    errors++;
                    $display("FAIL dir0 busy cycles 1..5: got %b want 01111", bh[5:1]);
                end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || {sum, cout, overflow} !== {es, ec, eo}) begin
                errors++;
                $display("FAIL dir%0d hold after done: got done=%b sum=%h want done=0 sum=%h",
                         i, done, sum, es);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] es;
        logic ec, eo;
        int lat;
        model(16'h1234, 16'h0FFF, 1'b0, es, ec, eo);
        a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);                      // cycle 1
        start = 1'b0;
        @(negedge clk);                      // cycle 2: stray start
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        lat = -1;
        for (int c = 3; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 5 || sum !== es || cout !== ec || overflow !== eo) begin
            errors++;
            $display("FAIL start_ignored: got lat=%0d sum=%h want lat=5 sum=%h", lat, sum, es);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored queued op: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] bh;
        logic [W-1:0] es;
        logic ec, eo;
        do_op(16'h1234, 16'h0FFF, 1'b0, lat, bh);
        // Still in the done cycle: issue the next operation immediately.
        do_op(16'h0001, 16'h0002, 1'b0, lat, bh);
        model(16'h0001, 16'h0002, 1'b0, es, ec, eo);
        checks++;
        if (lat !== 5 || sum !== 16'h0003 || sum !== es) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d sum=%h want lat=5 sum=0003", lat, sum);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [31:0] bh;
        logic seen_done;
        a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);                      // cycle 1
        start = 1'b0;
        @(negedge clk);                      // cycle 2
        @(negedge clk);                      // cycle 3
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, overflow} !== 20'd0) begin
            errors++;
            $display("FAIL mid_run reset: got busy=%b done=%b sum=%h c=%b o=%b want all 0",
                     busy, done, sum, cout, overflow);
        end
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_run no done: got done pulse want none");
        end
        do_op(16'h0005, 16'h0007, 1'b1, lat, bh);
        checks++;
        if (lat !== 5 || sum !== 16'hFFFE || overflow !== 1'b0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset op: got lat=%0d sum=%h o=%b c=%b want 5 fffe 0 0",
                     lat, sum, overflow, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, es;
        logic rs, ec, eo;
        int lat;
        logic [31:0] bh;
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            // Bias some operands toward the signed extremes.
            if ($urandom_range(0, 3) == 0) ra = {$urandom_range(0, 1) == 1, {(W-1){ra[0]}}};
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, es, ec, eo);
            do_op(ra, rb, rs, lat, bh);
            checks++;
            if (lat !== 5 || {sum, cout, overflow} !== {es, ec, eo}) begin
                errors++;
                $display("FAIL rand%0d %h %s %h: got lat=%0d sum=%h c=%b o=%b want 5 %h %b %b",
                         i, ra, rs ? "-" : "+", rb, lat, sum, cout, overflow, es, ec, eo);
            end
            // Randomly go back-to-back or idle for a cycle.
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that computes a WIDTH-bit two's-complement add or subtract by driving one 4-bit adder slice over successive clock cycles, one nibble per cycle, LSB first. It latches the operands, runs the slice `WIDTH/4` times while carrying between nibbles, and reports the sum, carry-out and signed overflow through a start/done handshake. It is the multi-cycle arithmetic unit for the lab datapath wherever one shared 4-bit adder must serve wide operands.

## Interface
- `WIDTH`, default 16: operand width. Must be a multiple of 4 and at least 4.
- `clk`  in  1: single clock; everything updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new operation. Sampled only in IDLE or DONE.
- `sub`  in  1: 0 computes a+b; 1 computes a−b. Latched with `start`.
- `a`  in  WIDTH: signed operand A. Latched with `start`.
- `b`  in  WIDTH: signed operand B. Latched with `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when the result becomes valid.
- `sum`  out  WIDTH: result. Held stable from `done` until the next accepted `start`.
- `cout`  out  1: carry out of bit WIDTH−1.
- `overflow`  out  1: signed overflow flag.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE, with `start`=1:
  - latch a, b and sub;
  - set the operand B register to `sub ? ~b : b`;
  - set carry to `sub`;
  - clear the nibble index k to 0;
  - go to RUN.
- RUN, each cycle:
  - drive the slice with nibble k of A, nibble k of B and the current carry;
  - write the slice sum into nibble k of the `sum` register;
  - store the slice carry-out as the new carry.
- On the last nibble (k = WIDTH/4−1):
  - capture `cout` as the slice carry-out;
  - capture `overflow` as the carry into bit WIDTH−1 XOR the carry out of bit WIDTH−1;
  - go to DONE.
- DONE: `done`=1 for exactly one cycle.
  - If `start`=1 in this cycle, the new operands are latched and the block goes straight to RUN (back-to-back operation).
  - Otherwise it goes to IDLE.
- `start` while in RUN is ignored. No queuing.
- `sum`, `cout` and `overflow` change only during RUN and at reset. They hold their values in IDLE and DONE.
- The partially written `sum` is visible during RUN and is not valid until `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `overflow`=0, state IDLE, k=0.
- Latency: with `start` accepted at edge 0, RUN covers edges 1..N where N = WIDTH/4. `done` is high in the cycle after edge N. With WIDTH=16, `done` is observed in cycle 5.
- Throughput: one operation per N+1 cycles when `start` is asserted back-to-back in DONE.
- Reset asserted mid-RUN aborts the operation. No `done` is produced, and all outputs return to their reset values on the next edge.
- `rst` and `start` in the same cycle: reset wins.
- WIDTH=4 degenerates to a single RUN cycle. `done` is observed 2 cycles after `start`.

## Configuration
- `SERIAL_ADD_SAT_EN` defined: when `overflow` is set on the last nibble, `sum` is replaced in the same edge by the saturated value.
  - If A's sign is 0, `sum` becomes 0111…1.
  - If A's sign is 1, `sum` becomes 1000…0.
  - `overflow` is still reported as 1.
- `SERIAL_ADD_SAT_EN` not defined: `sum` is the wrapped two's-complement result.
- Latency is identical in both builds.

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE, RUN, DONE);
  - the `NIBBLE_W`=4 constant;
  - the function returning the saturated max/min for a given width.
- One sub-module, `adder_4_slice`: purely combinational, inputs `a[3:0]`, `b[3:0]`, `cin`; outputs `s[3:0]`, `cout`, `c3`.
  - `c3` is the carry into bit 3, used for overflow detection.
- The controller owns the operand shift/select, the carry register, k, the FSM and the result register.

## Test plan
All scenarios use WIDTH=16.
- 0x1234 + 0x0FFF, sub=0 → `sum`=0x2233, `cout`=0, `overflow`=0. `done` observed exactly in cycle 5, `busy` high in cycles 1–4.
- 0x7FFF + 0x0001 → `overflow`=1, `cout`=0. `sum`=0x8000; 0x7FFF with `SERIAL_ADD_SAT_EN` defined.
- 0x8000 − 0x0001, sub=1 → `overflow`=1, `cout`=1. `sum`=0x7FFF; 0x8000 with `SERIAL_ADD_SAT_EN` defined.
- 0xFFFF + 0x0001 → `sum`=0x0000, `cout`=1, `overflow`=0.
- `start` pulsed again in cycle 2 with a=0x1111 → ignored; the first result completes unchanged. `start` in the `done` cycle with 0x0001+0x0002 → second `done` 5 cycles later with `sum`=0x0003.
- `rst` asserted in cycle 3 of RUN → no `done`. All outputs read 0 on the next cycle; a following 0x0005 − 0x0007 gives 0xFFFE, `overflow`=0.
